dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Responder end of the CPU data-memory port. It services word-aligned read and write requests, with byte enables, from the memory pipeline stage.
- Organisation: a direct-mapped, write-back, write-allocate cache with 256-bit lines.
- On a miss it writes back the dirty victim and then fills the line over a 256-bit physical-memory port.
- It sits between the MEM stage and the cacheline adaptor / arbiter.

Parameters:
- S_INDEX, 3: number of index bits. The cache has 2**S_INDEX sets.
- S_OFFSET, 5: byte-offset bits per line. Fixed at 5 (32-byte line); other values are unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mem_address  in  32  request address; bits [1:0] are ignored (requester supplies word-aligned addresses)
- mem_read  in  1  read request; held until mem_resp
- mem_write  in  1  write request; held until mem_resp
- mem_byte_enable  in  4  byte lanes to write; bit i covers mem_wdata[8i+7:8i]
- mem_wdata  in  32  store data, already lane-aligned by the requester
- mem_rdata  out  32  addressed word; valid only while mem_resp=1
- mem_resp  out  1  request complete; single-cycle pulse per request
- pmem_address  out  32  line address; bits [4:0] are always 0
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_wdata  out  256  victim line data
- pmem_rdata  in  256  fill line data; valid when pmem_resp=1
- pmem_resp  in  1  physical memory done

Behaviour:
- Address split:
  - tag = mem_address[31:S_OFFSET+S_INDEX]
  - index = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET]
  - word select = mem_address[4:2]
- Per set state: valid bit, dirty bit, tag, 256-bit data.
  - valid and dirty reset to 0.
  - Tag and data are not reset.
- Reset:
  - FSM goes to IDLE asynchronously.
  - All outputs are 0 while rst=1.
  - A fill or writeback in progress is abandoned: no array update, and no mem_resp for the aborted request.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE:
  - req = mem_read | mem_write.
  - hit = valid[index] & (tag_array[index] == tag).
  - req & hit:
    - mem_resp=1 combinationally in the same cycle.
    - Read: mem_rdata = data[index] word at word select.
    - Write: at the clock edge, bytes with byte_enable[i]=1 are written into that word and dirty[index] is set. Other bytes are unchanged.
    - Stay in IDLE.
  - req & !hit & valid & dirty: go to WRITEBACK.
  - req & !hit otherwise: go to FILL.
  - !req: no outputs asserted, no state change.
- WRITEBACK:
  - pmem_write=1.
  - pmem_address = {tag_array[index], index, 5'b0}.
  - pmem_wdata = data[index].
  - On pmem_resp: clear dirty[index] and go to FILL.
- FILL:
  - pmem_read=1.
  - pmem_address = {tag, index, 5'b0}.
  - On pmem_resp: data[index] <= pmem_rdata, tag_array[index] <= tag, valid <= 1, dirty <= 0, then go to IDLE.
  - The held request then hits in IDLE in the next cycle.
- Latency (cycle 0 = first cycle the request is presented):
  - Hit: mem_resp in cycle 0.
  - Clean miss: pmem_read rises in cycle 1. If pmem_resp arrives in cycle k, mem_resp is asserted in cycle k+1.
  - Dirty miss: the writeback comes first, then the fill follows in the cycle after the writeback pmem_resp.
- pmem_read and pmem_write are never asserted together. Each stays high continuously until its pmem_resp.
- mem_read and mem_write asserted together is illegal. The cache treats it as a write.
- Requester contract: address, byte enables and data are stable from request until mem_resp. The request drops or changes only after the mem_resp edge.
- Back-to-back hits: a new request may be presented in the cycle after mem_resp. The array update from the previous write is visible to it.
- mem_byte_enable = 4'b0000 on a write still completes and sets dirty.

Test Plan:
- Cold read of 0x0000_1044 after reset: FILL with pmem_address=0x0000_1040. Return a line whose word 1 = 0xDEADBEEF; mem_resp one cycle after pmem_resp with mem_rdata=0xDEADBEEF. Re-read gives mem_resp in the same cycle.
- Write hit to 0x0000_1044, be=4'b0100, wdata=0x00AB0000: read-back returns 0xDEABBEEF and dirty is set. No pmem activity.
- Dirty conflict: read 0x0000_2044 (same index, different tag) gives pmem_write with pmem_address=0x0000_1040 and word 1 = 0xDEABBEEF, then pmem_read with address 0x0000_2040, then mem_resp.
- Clean conflict: a read that evicts a clean line produces no pmem_write, only FILL.
- Reset asserted mid-FILL (pmem_resp withheld): pmem_read and mem_resp drop immediately. After release, a read of the same address misses again.
- Sub-word lane checks: 4 sequential byte writes (be 0001/0010/0100/1000, bytes 0x11/0x22/0x33/0x44) to 0x0000_3000 read back 0x44332211. Halfword write be=1100 with wdata 0xCAFE0000 reads back 0xCAFE2211.

Source files
------------

// File: rtl/dcache_responder_if.sv
// Data-memory port bundle for dcache_responder.
// Carries the CPU-side request/response signals (mem_*) and the line-wide
// physical-memory signals (pmem_*).
// Modports:
//   slave  - the cache: takes CPU requests and issues line fills and writebacks.
//   master - its environment: drives CPU requests and answers the pmem port.
interface dcache_responder_if;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-back, write-allocate data cache with
// 32-byte lines.  A hit answers in the cycle the request is presented.  A miss
// first writes back a dirty victim and then fills the line.  The request is
// held by the requester, so it then hits on the cycle after the fill.
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset
//   bus - dcache_responder_if.slave (CPU request side plus 256-bit pmem side)
module dcache_responder #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic                clk,
  input  logic                rst,
  dcache_responder_if.slave   bus
);
  localparam int NSETS = 2 ** S_INDEX;
  localparam int TAG_W = 32 - S_OFFSET - S_INDEX;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NSETS-1:0] r_valid;
  logic [NSETS-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag  [NSETS];
  logic [255:0]     r_data [NSETS];

  logic [TAG_W-1:0]   w_tag;
  logic [S_INDEX-1:0] w_index;
  logic [2:0]         w_word;
  logic [255:0]       w_line;
  logic               w_req;
  logic               w_hit;
  logic               w_hit_wr;
  logic               w_wb_done;
  logic               w_fill_done;
  logic               w_unused_addr;

  assign w_tag         = bus.mem_address[31:S_OFFSET+S_INDEX];
  assign w_index       = bus.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_word        = bus.mem_address[4:2];
  assign w_line        = r_data[w_index];
  assign w_req         = bus.mem_read | bus.mem_write;
  assign w_hit         = r_valid[w_index] & (r_tag[w_index] == w_tag);
  // The requester supplies word-aligned addresses, so the low bits carry nothing.
  assign w_unused_addr = ^bus.mem_address[1:0];

  // Merge the enabled byte lanes of a store word into one word of a line.
  function automatic logic [255:0] merge_line(input logic [255:0] line,
                                              input logic [2:0]   word,
                                              input logic [3:0]   be,
                                              input logic [31:0]  wdata);
    logic [255:0] v;
    v = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        v[{word, 5'd0} + 8'(b * 8) +: 8] = wdata[b*8 +: 8];
      end
    end
    return v;
  endfunction

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and all port outputs.  In reset the state is IDLE and
  // no set is valid, so nothing here can assert.
  always_comb begin
    w_state_nxt      = r_state;
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = 32'd0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = 32'd0;
    bus.pmem_wdata   = 256'd0;
    w_hit_wr         = 1'b0;
    w_wb_done        = 1'b0;
    w_fill_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && w_hit) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = w_line[{w_word, 5'd0} +: 32];
          // A read and a write asserted together are handled as a write.
          w_hit_wr      = bus.mem_write;
        end else if (w_req && r_valid[w_index] && r_dirty[w_index]) begin
          w_state_nxt = ST_WRITEBACK;
        end else if (w_req) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {r_tag[w_index], w_index, {S_OFFSET{1'b0}}};
        bus.pmem_wdata   = w_line;
        if (bus.pmem_resp) begin
          w_wb_done   = 1'b1;
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_WRITEBACK;
        end
      end
      ST_FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {w_tag, w_index, {S_OFFSET{1'b0}}};
        if (bus.pmem_resp) begin
          w_fill_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-set valid and dirty bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_fill_done) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end else if (w_wb_done) begin
        r_dirty[w_index] <= 1'b0;
      end else if (w_hit_wr) begin
        r_dirty[w_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays.  They have no reset.  Every write strobe needs a
  // valid line or the FILL state, and reset clears both, so a fill aborted
  // by reset leaves the arrays untouched.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[w_index] <= bus.pmem_rdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_hit_wr) begin
      r_data[w_index] <= merge_line(w_line, w_word, bus.mem_byte_enable, bus.mem_wdata);
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_responder_if bus();
  dcache_responder #(.S_INDEX(3), .S_OFFSET(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct { logic rd; logic [31:0] data; } sb_t;
  typedef struct { logic wr; logic [31:0] addr; logic [255:0] data; } pop_t;
  sb_t  sbq[$];
  pop_t pq[$];

  // Backing memory (line granularity) and the latest architectural word values.
  logic [255:0] pm    [logic [26:0]];
  logic [31:0]  ref_m [logic [29:0]];
  // Spec-level view of which line each set holds.
  logic         mvalid [8];
  logic         mdirty [8];
  logic [23:0]  mtag   [8];
  logic         withhold = 1'b0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic logic [255:0] gen_line(input logic [26:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ({5'd0, la} * 32'h9E3779B1) + 32'(w);
    return l;
  endfunction

  function automatic logic [255:0] pm_line(input logic [26:0] la);
    if (pm.exists(la)) return pm[la];
    return gen_line(la);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [255:0] l;
    if (ref_m.exists(a[31:2])) return ref_m[a[31:2]];
    l = pm_line(a[31:5]);
    return l[{a[4:2], 5'd0} +: 32];
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word(la + 32'(w * 4));
    return l;
  endfunction

  // Caller is at posedge+1; returns at posedge+1 after the completing edge.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, output logic [31:0] got);
    logic [2:0]  idx;
    logic [23:0] tg;
    logic        hit;
    logic        done;
    logic [31:0] w;
    idx = a[7:5];
    tg  = a[31:8];
    hit = mvalid[idx] && (mtag[idx] == tg);
    if (!hit) begin
      if (mvalid[idx] && mdirty[idx])
        pq.push_back('{1'b1, {mtag[idx], idx, 5'd0}, ref_line({mtag[idx], idx, 5'd0})});
      pq.push_back('{1'b0, {a[31:5], 5'd0}, 256'd0});
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      mdirty[idx] = 1'b0;
    end
    if (wr) begin
      w = ref_word(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      ref_m[a[31:2]] = w;
      mdirty[idx] = 1'b1;
      sbq.push_back('{1'b0, 32'd0});
    end else begin
      sbq.push_back('{1'b1, ref_word(a)});
    end
    bus.mem_address = a;
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata = wd;
    got = 32'd0;
    done = 1'b0;
    @(negedge clk);
    chk("resp_cycle0", bus.mem_resp, hit);
    if (bus.mem_resp) begin done = 1'b1; got = bus.mem_rdata; end
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_resp) begin done = 1'b1; got = bus.mem_rdata; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL req_timeout got no mem_resp exp mem_resp addr %h", a);
    end
    @(posedge clk); #1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Scoreboard monitor: every mem_resp consumes one expected response.
  always @(negedge clk) begin : mon
    sb_t e;
    if (!rst && bus.mem_resp) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp got mem_resp exp none");
      end else begin
        e = sbq.pop_front();
        if (e.rd) chk("rdata", bus.mem_rdata, e.data);
      end
    end
  end

  // Physical memory: checks each line request against expectations, replies after a random delay.
  logic pend = 1'b0;
  int   dly  = 0;
  pop_t cur;
  always @(negedge clk) begin : pmem_p
    pop_t e;
    if (rst) begin
      pend = 1'b0;
      bus.pmem_resp = 1'b0;
    end else if (bus.pmem_resp) begin
      bus.pmem_resp = 1'b0;
      pend = 1'b0;
      if (!cur.wr) chk("fill_to_resp", bus.mem_resp, 1'b1);
    end else if (bus.pmem_read || bus.pmem_write) begin
      if (bus.pmem_read && bus.pmem_write) chk("pmem_excl", 2'b11, 2'b01);
      if (!pend) begin
        pend = 1'b1;
        dly  = $urandom_range(0, 3);
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pmem got op at %h exp none", bus.pmem_address);
          cur = '{bus.pmem_write, bus.pmem_address, 256'd0};
        end else begin
          e = pq.pop_front();
          cur = e;
          chk("pmem_kind", bus.pmem_write, e.wr);
          chk("pmem_addr", bus.pmem_address, e.addr);
          if (e.wr) chk("pmem_wdata", bus.pmem_wdata, e.data);
        end
      end
      if (!withhold) begin
        if (dly == 0) begin
          if (bus.pmem_write) pm[bus.pmem_address[31:5]] = bus.pmem_wdata;
          else bus.pmem_rdata = pm_line(bus.pmem_address[31:5]);
          bus.pmem_resp = 1'b1;
        end else begin
          dly--;
        end
      end
    end else if (pend) begin
      chk("pmem_held", 1'b0, 1'b1);
      pend = 1'b0;
    end
  end

  initial begin
    logic [31:0]  got;
    logic [255:0] l;
    logic [31:0]  r;
    logic [31:0]  a;
    logic         rd;
    logic         wr;
    bus.mem_address = 32'd0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_byte_enable = 4'd0; bus.mem_wdata = 32'd0;
    bus.pmem_rdata = 256'd0; bus.pmem_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin mvalid[i] = 1'b0; mdirty[i] = 1'b0; mtag[i] = 24'd0; end
    l = gen_line(27'h1040 >> 5);
    l[63:32] = 32'hDEADBEEF;
    pm[27'h1040 >> 5] = l;

    repeat (3) @(negedge clk);
    chk("rst_mem_resp", bus.mem_resp, 1'b0);
    chk("rst_pmem_rw", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("rst_pmem_addr", bus.pmem_address, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b1, 1'b0, 32'h0000_1044, 4'hF, 32'd0, got);
    chk("cold_read", got, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h0000_1044, 4'hF, 32'd0, got);
    chk("reread_hit", got, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 32'h0000_1044, 4'b0100, 32'h00AB_0000, got);
    do_req(1'b1, 1'b0, 32'h0000_1044, 4'hF, 32'd0, got);
    chk("write_merge", got, 32'hDEABBEEF);
    do_req(1'b1, 1'b0, 32'h0000_2044, 4'hF, 32'd0, got);
    l = pm_line(27'h1040 >> 5);
    chk("writeback_word1", l[63:32], 32'hDEABBEEF);
    do_req(1'b1, 1'b0, 32'h0000_1044, 4'hF, 32'd0, got);
    chk("clean_evict_read", got, 32'hDEABBEEF);

    // Reset in the middle of a withheld fill.
    pq.push_back('{1'b0, 32'h0000_5040, 256'd0});
    withhold = 1'b1;
    bus.mem_address = 32'h0000_5048; bus.mem_read = 1'b1; bus.mem_byte_enable = 4'hF;
    repeat (4) @(negedge clk);
    chk("fill_pending", bus.pmem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drop_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_drop_resp", bus.mem_resp, 1'b0);
    bus.mem_read = 1'b0;
    withhold = 1'b0;
    for (int i = 0; i < 8; i++) begin mvalid[i] = 1'b0; mdirty[i] = 1'b0; end
    ref_m.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 32'h0000_5048, 4'hF, 32'd0, got);

    // Byte and halfword lanes.
    do_req(1'b0, 1'b1, 32'h0000_3000, 4'b0001, 32'h0000_0011, got);
    do_req(1'b0, 1'b1, 32'h0000_3000, 4'b0010, 32'h0000_2200, got);
    do_req(1'b0, 1'b1, 32'h0000_3000, 4'b0100, 32'h0033_0000, got);
    do_req(1'b0, 1'b1, 32'h0000_3000, 4'b1000, 32'h4400_0000, got);
    do_req(1'b1, 1'b0, 32'h0000_3000, 4'hF, 32'd0, got);
    chk("bytes_readback", got, 32'h4433_2211);
    do_req(1'b0, 1'b1, 32'h0000_3000, 4'b1100, 32'hCAFE_0000, got);
    do_req(1'b1, 1'b0, 32'h0000_3000, 4'hF, 32'd0, got);
    chk("half_readback", got, 32'hCAFE_2211);
    do_req(1'b0, 1'b1, 32'h0000_3000, 4'b0000, 32'hFFFF_FFFF, got);
    do_req(1'b1, 1'b0, 32'h0000_3000, 4'hF, 32'd0, got);
    chk("be0_unchanged", got, 32'hCAFE_2211);

    // Randomised traffic over a few conflicting tags.
    for (int n = 0; n < 300; n++) begin
      r  = $urandom;
      a  = {16'd0, 6'd4, r[1:0], r[4:2], r[7:5], 2'b00};
      wr = (r[11:8] < 4'd7) || (r[11:8] == 4'd15);
      rd = !wr || (r[11:8] == 4'd15);
      do_req(rd, wr, a, r[15:12], $urandom, got);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("pmem_drained", 32'(pq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
